// File: rtl/program_loader.sv
// Boot loader: parses MAGIC/LEN/words/CSUM byte frames into instruction memory, then releases the core.
// One byte per cycle; word write lands 1 cycle after its last byte; rx_ready drops only in RUN/ERROR.
module program_loader #(
  parameter int          INST_W   = 16,
  parameter int          I_ADDR_W = 12,
  parameter logic [7:0]  MAGIC    = 8'hA5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  input  logic                reload,
  output logic [I_ADDR_W-1:0] imem_waddr,
  output logic [INST_W-1:0]   imem_wdata,
  output logic                imem_we,
  output logic                core_reset_n,
  output logic                load_done,
  output logic                load_error
);

  localparam int INST_W_BYTES = INST_W / 8;
  localparam int BI_W         = (INST_W_BYTES > 1) ? $clog2(INST_W_BYTES) : 1;
  localparam logic [BI_W-1:0] LAST_IDX = BI_W'(INST_W_BYTES - 1);

  typedef enum logic [2:0] {
    S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RUN, S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [11:0]         len_q, len_d;
  logic [I_ADDR_W-1:0] word_cnt_q, word_cnt_d, word_cnt_inc;
  logic [BI_W-1:0]     byte_idx_q, byte_idx_d;
  logic [INST_W-1:0]   asm_q, asm_d, word_nxt;
  logic [7:0]          csum_q, csum_d;
  logic [I_ADDR_W-1:0] imem_waddr_q, imem_waddr_d;
  logic [INST_W-1:0]   imem_wdata_q, imem_wdata_d;
  logic                imem_we_q, imem_we_d;
  logic                core_reset_n_q, core_reset_n_d;
  logic                load_done_q, load_done_d;
  logic                load_error_q, load_error_d;
  logic                rx_accept;

  assign rx_ready     = (state_q != S_RUN) && (state_q != S_ERROR);
  assign rx_accept    = rx_valid && rx_ready;
  assign imem_waddr   = imem_waddr_q;
  assign imem_wdata   = imem_wdata_q;
  assign imem_we      = imem_we_q;
  assign core_reset_n = core_reset_n_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    word_cnt_d     = word_cnt_q;
    byte_idx_d     = byte_idx_q;
    asm_d          = asm_q;
    csum_d         = csum_q;
    imem_waddr_d   = imem_waddr_q;
    imem_wdata_d   = imem_wdata_q;
    imem_we_d      = 1'b0;
    core_reset_n_d = core_reset_n_q;
    load_done_d    = load_done_q;
    load_error_d   = load_error_q;
    word_cnt_inc   = word_cnt_q + I_ADDR_W'(1);
    word_nxt       = asm_q;
    word_nxt[byte_idx_q*8 +: 8] = rx_data;

    case (state_q)
      S_SYNC: begin
        if (rx_accept && rx_data == MAGIC) begin
          state_d    = S_LEN_LO;
          csum_d     = 8'h00;
          word_cnt_d = '0;
          byte_idx_d = '0;
        end
      end
      S_LEN_LO: begin
        if (rx_accept) begin
          len_d   = {4'h0, rx_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_accept) begin
          if (rx_data[7:4] != 4'h0) begin
            state_d      = S_ERROR;
            load_error_d = 1'b1;
          end else begin
            len_d   = {rx_data[3:0], len_q[7:0]};
            state_d = ({rx_data[3:0], len_q[7:0]} == 12'd0) ? S_CSUM : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_accept) begin
          csum_d = csum_q + rx_data;
          asm_d  = word_nxt;
          if (byte_idx_q == LAST_IDX) begin
            byte_idx_d   = '0;
            imem_wdata_d = word_nxt;
            imem_waddr_d = word_cnt_q;
            imem_we_d    = 1'b1;
            word_cnt_d   = word_cnt_inc;
            if (word_cnt_inc == I_ADDR_W'(len_q)) state_d = S_CSUM;
          end else begin
            byte_idx_d = byte_idx_q + BI_W'(1);
          end
        end
      end
      S_CSUM: begin
        if (rx_accept) begin
          if (rx_data == csum_q) begin
            state_d        = S_RUN;
            core_reset_n_d = 1'b1;
            load_done_d    = 1'b1;
          end else begin
            state_d      = S_ERROR;
            load_error_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (reload) begin
          state_d        = S_SYNC;
          core_reset_n_d = 1'b0;
          load_done_d    = 1'b0;
        end
      end
      S_ERROR: begin
        if (reload) begin
          state_d      = S_SYNC;
          load_error_d = 1'b0;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_SYNC;
      len_q          <= '0;
      word_cnt_q     <= '0;
      byte_idx_q     <= '0;
      asm_q          <= '0;
      csum_q         <= 8'h00;
      imem_waddr_q   <= '0;
      imem_wdata_q   <= '0;
      imem_we_q      <= 1'b0;
      core_reset_n_q <= 1'b0;
      load_done_q    <= 1'b0;
      load_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      word_cnt_q     <= word_cnt_d;
      byte_idx_q     <= byte_idx_d;
      asm_q          <= asm_d;
      csum_q         <= csum_d;
      imem_waddr_q   <= imem_waddr_d;
      imem_wdata_q   <= imem_wdata_d;
      imem_we_q      <= imem_we_d;
      core_reset_n_q <= core_reset_n_d;
      load_done_q    <= load_done_d;
      load_error_q   <= load_error_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames driven on negedge, outputs sampled on negedge.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic [11:0] imem_waddr;
  logic [15:0] imem_wdata;
  logic        imem_we;
  logic        core_reset_n;
  logic        load_done;
  logic        load_error;

  int checks = 0;
  int errors = 0;
  int we_total = 0;
  int we_base;

  logic [7:0]  good [0:9] = '{8'hA5, 8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'h6A};
  logic [15:0] words [0:2] = '{16'h1234, 16'h5678, 16'h9ABC};

  program_loader #(.INST_W(16), .I_ADDR_W(12), .MAGIC(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .reload(reload), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .imem_we(imem_we), .core_reset_n(core_reset_n),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we === 1'b1) we_total <= we_total + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one byte after 'gap' idle cycles; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_good(input int maxgap, input logic [7:0] csum);
    logic [7:0] b;
    int gap;
    for (int i = 0; i < 10; i++) begin
      b   = (i == 9) ? csum : good[i];
      gap = (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0;
      send(b, gap);
      if (i == 4 || i == 6 || i == 8) begin
        chk("we_pulse", 32'(imem_we), 32'd1);
        chk("waddr", 32'(imem_waddr), 32'((i - 4) / 2));
        chk("wdata", 32'(imem_wdata), 32'(words[(i - 4) / 2]));
      end else if (i < 9) begin
        chk("we_idle", 32'(imem_we), 32'd0);
      end
      if (i == 8) chk("done_before_csum", 32'(load_done), 32'd0);
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic chk_run(input string tag);
    chk({tag, "_done"}, 32'(load_done), 32'd1);
    chk({tag, "_core_rst"}, 32'(core_reset_n), 32'd1);
    chk({tag, "_err"}, 32'(load_error), 32'd0);
    chk({tag, "_ready"}, 32'(rx_ready), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    reload   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_waddr", 32'(imem_waddr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_core", 32'(core_reset_n), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_error), 32'd0);
    chk("rst_ready", 32'(rx_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic good frame
    we_base = we_total;
    send_good(0, 8'h6A);
    chk_run("good");
    chk("good_we_count", 32'(we_total - we_base), 32'd3);
    repeat (3) @(negedge clk);
    chk("good_hold_done", 32'(load_done), 32'd1);
    chk("good_hold_ready", 32'(rx_ready), 32'd0);
    pulse_reload();
    chk("reload_done", 32'(load_done), 32'd0);
    chk("reload_core", 32'(core_reset_n), 32'd0);
    chk("reload_ready", 32'(rx_ready), 32'd1);

    // Junk ahead of MAGIC is discarded
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'h5A, 0);
    chk("junk_we", 32'(imem_we), 32'd0);
    we_base = we_total;
    send_good(0, 8'h6A);
    chk_run("junk");
    chk("junk_we_count", 32'(we_total - we_base), 32'd3);
    pulse_reload();

    // Bad checksum
    send_good(0, 8'h6B);
    chk("bad_err", 32'(load_error), 32'd1);
    chk("bad_core", 32'(core_reset_n), 32'd0);
    chk("bad_done", 32'(load_done), 32'd0);
    chk("bad_ready", 32'(rx_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("bad_hold_err", 32'(load_error), 32'd1);
    pulse_reload();
    chk("bad_reload_err", 32'(load_error), 32'd0);
    chk("bad_reload_ready", 32'(rx_ready), 32'd1);
    send_good(0, 8'h6A);
    chk_run("retry");
    pulse_reload();

    // Length high nibble set
    we_base = we_total;
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h10, 0);
    chk("lenhi_err", 32'(load_error), 32'd1);
    chk("lenhi_ready", 32'(rx_ready), 32'd0);
    chk("lenhi_no_we", 32'(we_total - we_base), 32'd0);
    pulse_reload();
    chk("lenhi_clear", 32'(load_error), 32'd0);

    // Zero-length frame
    we_base = we_total;
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    chk("zero_not_done", 32'(load_done), 32'd0);
    send(8'h00, 0);
    chk_run("zero");
    chk("zero_no_we", 32'(we_total - we_base), 32'd0);
    pulse_reload();

    // Gaps in rx_valid
    we_base = we_total;
    send_good(5, 8'h6A);
    chk_run("gap");
    chk("gap_we_count", 32'(we_total - we_base), 32'd3);
    pulse_reload();

    // Asynchronous reset after the first word write
    send(8'hA5, 0);
    send(8'h03, 0);
    send(8'h00, 0);
    send(8'h34, 0);
    send(8'h12, 0);
    chk("mid_we", 32'(imem_we), 32'd1);
    chk("mid_wdata", 32'(imem_wdata), 32'h1234);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_we", 32'(imem_we), 32'd0);
    chk("arst_waddr", 32'(imem_waddr), 32'd0);
    chk("arst_wdata", 32'(imem_wdata), 32'd0);
    chk("arst_core", 32'(core_reset_n), 32'd0);
    chk("arst_done", 32'(load_done), 32'd0);
    chk("arst_err", 32'(load_error), 32'd0);
    chk("arst_ready", 32'(rx_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    we_base = we_total;
    send_good(0, 8'h6A);
    chk_run("post_rst");
    chk("post_rst_we_count", 32'(we_total - we_base), 32'd3);
    reload = 1'b1;
    @(posedge clk);
    #1;
    chk("run_reload_core", 32'(core_reset_n), 32'd0);
    chk("run_reload_done", 32'(load_done), 32'd0);
    @(negedge clk);
    reload = 1'b0;
    chk("run_reload_ready", 32'(rx_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
